xing_scheduler: RTL and testbench

Request scheduler and phase timer for the highway/secondary/pedestrian intersection. Latches secondary-road car (S) and pedestrian button (P) requests, arbitrates between them round-robin when the highway light FSM asks for a service slot, and supplies the timed strobes that FSM uses for every phase (highway minimum green, yellow, secondary green, pedestrian walk). It sits beside the light FSM; the FSM drives the LEDs, this block decides who is served next and when phases expire.

---
 rtl/xing_pkg.sv | 26 ++
 rtl/xing_scheduler_if.sv | 23 ++
 rtl/xing_phase_timer.sv | 102 ++++++++++
 rtl/xing_scheduler.sv | 97 +++++++++
 tb/tb_xing_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/xing_pkg.sv
// Shared encodings for the intersection request scheduler: timer selects,
// arbiter states, served-type constants and a width helper.
package xing_pkg;

   typedef enum logic [1:0] {
      TMR_HWY_MIN   = 2'd0,
      TMR_YELLOW    = 2'd1,
      TMR_SEC_GREEN = 2'd2,
      TMR_PED_WALK  = 2'd3
   } tmr_sel_t;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   typedef enum logic {
      SERVED_SEC = 1'b0,
      SERVED_PED = 1'b1
   } served_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/xing_scheduler_if.sv
// Handshake bundle between the highway light FSM (master) and the scheduler (slave).
interface xing_scheduler_if;
   logic       tmr_start;
   logic [1:0] tmr_sel;
   logic       tmr_busy;
   logic       tmr_done;
   logic       arb_req;
   logic       svc_done;
   logic       svc_pending;
   logic       gnt_sec;
   logic       gnt_ped;
   logic       gnt_none;

   modport master (
      output tmr_start, tmr_sel, arb_req, svc_done,
      input  tmr_busy, tmr_done, svc_pending, gnt_sec, gnt_ped, gnt_none
   );

   modport slave (
      input  tmr_start, tmr_sel, arb_req, svc_done,
      output tmr_busy, tmr_done, svc_pending, gnt_sec, gnt_ped, gnt_none
   );
endinterface

// File: rtl/xing_phase_timer.sv
// Phase timer: prescaler to ticks, per-phase tick countdown, optional secondary
// green extension (enabled by defining SEC_EXTEND_EN).
module xing_phase_timer
   import xing_pkg::*;
#(
   parameter int TICK_DIV    = 50_000_000,
   parameter int HWY_MIN_T   = 10,
   parameter int YELLOW_T    = 3,
   parameter int SEC_GREEN_T = 6,
   parameter int SEC_MAX_T   = 12,
   parameter int PED_WALK_T  = 8
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       tmr_start,
   input  logic [1:0] tmr_sel,
   input  logic       C,
   output logic       tmr_busy,
   output logic       tmr_done
);

   localparam int MAX_T = max_of(max_of(HWY_MIN_T, YELLOW_T),
                                 max_of(max_of(SEC_GREEN_T, SEC_MAX_T), PED_WALK_T));
   localparam int CW = $clog2(MAX_T + 1);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc;
   logic [CW-1:0] remain;
   logic [CW-1:0] load_val;
   logic          tick;
   logic          extend;

   always_comb begin
      load_val = CW'(HWY_MIN_T);
      case (tmr_sel)
         TMR_HWY_MIN:   load_val = CW'(HWY_MIN_T);
         TMR_YELLOW:    load_val = CW'(YELLOW_T);
         TMR_SEC_GREEN: load_val = CW'(SEC_GREEN_T);
         TMR_PED_WALK:  load_val = CW'(PED_WALK_T);
         default:       load_val = CW'(HWY_MIN_T);
      endcase
   end

   assign tick = tmr_busy && (presc == PW'(TICK_DIV - 1));

`ifdef SEC_EXTEND_EN
   logic          sec_run;
   logic [CW-1:0] total;

   // total tracks elapsed+remaining so the extension stops at the ceiling
   assign extend = sec_run && C && (total < CW'(SEC_MAX_T));

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         sec_run <= 1'b0;
         total   <= '0;
      end else if (tmr_start) begin
         sec_run <= (tmr_sel == TMR_SEC_GREEN);
         total   <= load_val;
      end else if (tick && extend) begin
         total   <= total + 1'b1;
      end
   end
`else
   logic unused_c;
   assign unused_c = C;
   assign extend   = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         presc    <= '0;
         remain   <= '0;
         tmr_busy <= 1'b0;
         tmr_done <= 1'b0;
      end else begin
         tmr_done <= 1'b0;
         if (tmr_start) begin
            // a start while busy silently abandons the previous run
            presc    <= '0;
            remain   <= load_val;
            tmr_busy <= 1'b1;
         end else if (tmr_busy) begin
            if (tick) begin
               presc <= '0;
               if (!extend) begin
                  if (remain <= CW'(1)) begin
                     remain   <= '0;
                     tmr_busy <= 1'b0;
                     tmr_done <= 1'b1;
                  end else begin
                     remain <= remain - 1'b1;
                  end
               end
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/xing_scheduler.sv
// Request latches and round-robin service arbiter for the intersection, plus the
// phase timer instance. Optional feature macro: SEC_EXTEND_EN (see xing_phase_timer).
module xing_scheduler
   import xing_pkg::*;
#(
   parameter int TICK_DIV    = 50_000_000,
   parameter int HWY_MIN_T   = 10,
   parameter int YELLOW_T    = 3,
   parameter int SEC_GREEN_T = 6,
   parameter int SEC_MAX_T   = 12,
   parameter int PED_WALK_T  = 8
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             S,
   input  logic             P,
   input  logic             C,
   xing_scheduler_if.slave  bus
);

   arb_state_t state;
   served_t    last_served;
   logic       p_dly;
   logic       s_pend;
   logic       p_pend;
   logic       s_req;
   logic       p_req;

   // same-cycle requests are folded in so they take part in this arbitration
   assign s_req = s_pend | (S & ~bus.gnt_sec);
   assign p_req = p_pend | (P & ~p_dly & ~bus.gnt_ped);

   assign bus.svc_pending = s_pend | p_pend;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state        <= ARB_IDLE;
         last_served  <= SERVED_PED;
         p_dly        <= 1'b0;
         s_pend       <= 1'b0;
         p_pend       <= 1'b0;
         bus.gnt_sec  <= 1'b0;
         bus.gnt_ped  <= 1'b0;
         bus.gnt_none <= 1'b0;
      end else begin
         p_dly        <= P;
         s_pend       <= s_req;
         p_pend       <= p_req;
         bus.gnt_none <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (bus.arb_req) begin
                  if (s_req && (!p_req || last_served == SERVED_PED)) begin
                     bus.gnt_sec <= 1'b1;
                     s_pend      <= 1'b0;
                     last_served <= SERVED_SEC;
                     state       <= ARB_GRANT;
                  end else if (p_req) begin
                     bus.gnt_ped <= 1'b1;
                     p_pend      <= 1'b0;
                     last_served <= SERVED_PED;
                     state       <= ARB_GRANT;
                  end else begin
                     bus.gnt_none <= 1'b1;
                  end
               end
            end
            ARB_GRANT: begin
               if (bus.svc_done) begin
                  bus.gnt_sec <= 1'b0;
                  bus.gnt_ped <= 1'b0;
                  state       <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   xing_phase_timer #(
      .TICK_DIV    (TICK_DIV),
      .HWY_MIN_T   (HWY_MIN_T),
      .YELLOW_T    (YELLOW_T),
      .SEC_GREEN_T (SEC_GREEN_T),
      .SEC_MAX_T   (SEC_MAX_T),
      .PED_WALK_T  (PED_WALK_T)
   ) u_timer (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .tmr_start (bus.tmr_start),
      .tmr_sel   (bus.tmr_sel),
      .C         (C),
      .tmr_busy  (bus.tmr_busy),
      .tmr_done  (bus.tmr_done)
   );

endmodule

// File: tb/tb_xing_scheduler.sv
// Scoreboard bench for xing_scheduler: stimulus pushes expected outputs per edge,
// a separate monitor pops and compares them.
module tb_xing_scheduler;

   localparam int TDIV   = 4;
   localparam int HWY_T  = 10;
   localparam int YEL_T  = 3;
   localparam int SECG_T = 6;
   localparam int SECM_T = 12;
   localparam int PED_T  = 8;

   logic Clock = 1'b0;
   logic Resetn = 1'b0;
   logic S = 1'b0;
   logic P = 1'b0;
   logic C = 1'b0;

   xing_scheduler_if bus();

   xing_scheduler #(
      .TICK_DIV    (TDIV),
      .HWY_MIN_T   (HWY_T),
      .YELLOW_T    (YEL_T),
      .SEC_GREEN_T (SECG_T),
      .SEC_MAX_T   (SECM_T),
      .PED_WALK_T  (PED_T)
   ) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .S      (S),
      .P      (P),
      .C      (C),
      .bus    (bus)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      int ecyc;
      bit busy, done, gs, gp, gn, pend;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit m_s, m_p, m_gs, m_gp, m_last_ped, m_pprev, m_tact;
   int m_tdone;
   bit c_hold;

   task automatic chk(input string name, input bit act, input bit req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0b, expected %0b", name, cyc, act, req);
      end
   endtask

   function automatic int dur_of(input bit [1:0] sel, input bit c);
      int d;
      case (sel)
         2'd0: d = HWY_T;
         2'd1: d = YEL_T;
         2'd2: d = SECG_T;
         default: d = PED_T;
      endcase
`ifdef SEC_EXTEND_EN
      // with C held for the whole run, green stretches to the ceiling
      if (sel == 2'd2 && c) d = SECM_T;
`endif
      return d;
   endfunction

   task automatic drive(input bit rstn, input bit s, input bit p, input bit arb,
                        input bit sdone, input bit ts, input bit [1:0] sel);
      exp_t e;
      bit prise, sr, pr;
      @(negedge Clock);
      Resetn = rstn; S = s; P = p; C = c_hold;
      bus.arb_req = arb; bus.svc_done = sdone; bus.tmr_start = ts; bus.tmr_sel = sel;
      e.ecyc = cyc + 1;
      e.gn = 1'b0;
      if (!rstn) begin
         m_s = 0; m_p = 0; m_gs = 0; m_gp = 0; m_last_ped = 1; m_pprev = 0; m_tact = 0;
      end else begin
         prise = p && !m_pprev;
         sr = m_s || (s && !m_gs);
         pr = m_p || (prise && !m_gp);
         if (!m_gs && !m_gp) begin
            if (arb) begin
               if (sr && pr) begin
                  if (m_last_ped) begin m_gs = 1; sr = 0; m_last_ped = 0; end
                  else begin m_gp = 1; pr = 0; m_last_ped = 1; end
               end else if (sr) begin
                  m_gs = 1; sr = 0; m_last_ped = 0;
               end else if (pr) begin
                  m_gp = 1; pr = 0; m_last_ped = 1;
               end else begin
                  e.gn = 1'b1;
               end
            end
         end else if (sdone) begin
            m_gs = 0; m_gp = 0;
         end
         m_s = sr; m_p = pr; m_pprev = p;
         if (ts) begin
            m_tact = 1;
            m_tdone = e.ecyc + dur_of(sel, c_hold) * TDIV;
         end
      end
      e.busy = m_tact && (e.ecyc < m_tdone);
      e.done = m_tact && (e.ecyc == m_tdone);
      if (e.done) m_tact = 0;
      e.gs = m_gs; e.gp = m_gp; e.pend = m_s || m_p;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 2'd0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 2'd0);
   endtask

   // monitor: compare every expected edge once the DUT has settled after it
   initial begin
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         while (q.size() > 0 && q[0].ecyc < cyc) begin
            e = q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL missed_check edge %0d: monitor reached cycle %0d, expected edge %0d", e.ecyc, cyc, e.ecyc);
         end
         if (q.size() > 0 && q[0].ecyc == cyc) begin
            e = q.pop_front();
            chk("tmr_busy",    bus.tmr_busy,    e.busy);
            chk("tmr_done",    bus.tmr_done,    e.done);
            chk("gnt_sec",     bus.gnt_sec,     e.gs);
            chk("gnt_ped",     bus.gnt_ped,     e.gp);
            chk("gnt_none",    bus.gnt_none,    e.gn);
            chk("svc_pending", bus.svc_pending, e.pend);
         end
      end
   end

   initial begin
      bus.tmr_start = 0; bus.tmr_sel = 0; bus.arb_req = 0; bus.svc_done = 0;
      c_hold = 0;
      do_reset(3);
      idle(2);

      // yellow: 3 ticks of 4 cycles
      drive(1, 0, 0, 0, 0, 1, 2'd1);
      idle(14);

      // single secondary request
      drive(1, 1, 0, 0, 0, 0, 2'd0);
      idle(1);
      drive(1, 0, 0, 1, 0, 0, 2'd0);
      idle(2);
      drive(1, 0, 0, 0, 1, 0, 2'd0);
      idle(2);

      // contested rounds from a fresh last_served
      do_reset(2);
      for (int r = 0; r < 3; r++) begin
         drive(1, 1, 1, 0, 0, 0, 2'd0);
         idle(1);
         drive(1, 0, 0, 1, 0, 0, 2'd0);
         idle(2);
         drive(1, 0, 0, 1, 0, 0, 2'd0);
         drive(1, 0, 0, 0, 1, 0, 2'd0);
         idle(1);
      end
      // drain remaining pending request, then empty arbitration
      drive(1, 0, 0, 1, 0, 0, 2'd0);
      drive(1, 0, 0, 0, 1, 0, 2'd0);
      drive(1, 0, 0, 1, 0, 0, 2'd0);
      idle(2);
      drive(1, 0, 0, 0, 1, 0, 2'd0);
      drive(1, 0, 0, 1, 0, 0, 2'd0);
      idle(2);

      // secondary green with car present, then without
      c_hold = 1;
      drive(1, 0, 0, 0, 0, 1, 2'd2);
      idle(SECM_T * TDIV + 3);
      c_hold = 0;
      drive(1, 0, 0, 0, 0, 1, 2'd2);
      idle(SECG_T * TDIV + 3);

      // restart mid-run
      drive(1, 0, 0, 0, 0, 1, 2'd3);
      idle(10);
      drive(1, 0, 0, 0, 0, 1, 2'd1);
      idle(YEL_T * TDIV + 3);

      // reset during a pedestrian grant and a running timer
      drive(1, 0, 1, 0, 0, 0, 2'd0);
      drive(1, 0, 0, 1, 0, 0, 2'd0);
      drive(1, 1, 0, 0, 0, 1, 2'd0);
      idle(5);
      do_reset(2);
      idle(HWY_T * TDIV + 5);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         bit rn, s, p, a, d, ts;
         bit [1:0] sel;
         rn  = ($urandom_range(0, 299) != 0);
         s   = ($urandom_range(0, 3) == 0);
         p   = ($urandom_range(0, 2) == 0);
         a   = ($urandom_range(0, 5) == 0);
         d   = ($urandom_range(0, 7) == 0);
         ts  = ($urandom_range(0, 59) == 0);
         sel = 2'($urandom_range(0, 3));
         if (ts) c_hold = 1'($urandom_range(0, 1));
         drive(rn, s, p, a, d, ts, sel);
      end
      idle(2);

      repeat (3) @(posedge Clock);
      #2;
      if (q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL leftover_expectations: %0d remaining, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
